// File: rtl/fifo_wptr_full.sv
// Write-domain half of an async FIFO: binary/Gray write pointer, 2-flop read-pointer
// synchronizer, and registered full / almost-full / fill-level / overflow flags.
module fifo_wptr_full #(
    parameter int PTR      = 5,
    parameter int AF_LEVEL = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [PTR-1:0] rptr_gray_async,
    output logic [PTR-2:0] waddr,
    output logic           wr_accept,
    output logic [PTR-1:0] wptr_gray,
    output logic           full,
    output logic           almost_full,
    output logic [PTR-1:0] wr_count,
    output logic           overflow
);

    localparam logic [PTR-1:0] AF_THRESH = PTR'(AF_LEVEL);

    logic [PTR-1:0] wbin;
    logic [PTR-1:0] wbin_next;
    logic [PTR-1:0] wgray_next;
    logic [PTR-1:0] rq1;
    logic [PTR-1:0] rq2;
    logic [PTR-1:0] rbin;
    logic [PTR-1:0] fill_next;
    logic [PTR-1:0] full_match;

    assign wr_accept  = wr_en & ~full;
    assign wbin_next  = wbin + PTR'(wr_accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign fill_next  = wbin_next - rbin;
    assign waddr      = wbin[PTR-2:0];

    // Full when the write pointer is exactly one lap ahead: in Gray this is the
    // synchronized read pointer with its top two bits inverted.
    assign full_match = {~rq2[PTR-1:PTR-2], rq2[PTR-3:0]};

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PTR; i++) begin
            rbin[i] = ^(rq2 >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr_gray_async;
            rq2 <= rq1;
        end
    end

    // Flags use next-state pointer values so they line up with the pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == full_match);
            almost_full <= (fill_next >= AF_THRESH);
            wr_count    <= fill_next;
            overflow    <= wr_en & full;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed scenarios plus random traffic, checked against
// a counter-level model of writes, a delayed read pointer and fill arithmetic.
module tb_fifo_wptr_full;

    localparam int PTR   = 5;
    localparam int AF    = 12;
    localparam int DEPTH = 16;
    localparam int MODV  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           wr_en = 1'b0;
    logic [PTR-1:0] rptr_gray_async = '0;
    logic [PTR-2:0] waddr;
    logic           wr_accept;
    logic [PTR-1:0] wptr_gray;
    logic           full;
    logic           almost_full;
    logic [PTR-1:0] wr_count;
    logic           overflow;

    fifo_wptr_full #(.PTR(PTR), .AF_LEVEL(AF)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .rptr_gray_async (rptr_gray_async),
        .waddr           (waddr),
        .wr_accept       (wr_accept),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .wr_count        (wr_count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: accepted-write count, driven read pointer, and the history of read
    // pointers sampled at each edge (the write side sees them two edges late).
    int wcnt   = 0;
    int rd     = 0;
    int m_fill = 0;
    bit m_full = 1'b0;
    bit m_af   = 1'b0;
    bit m_ovf  = 1'b0;
    int hist[$];

    function automatic logic [PTR-1:0] to_gray(input int b);
        logic [PTR-1:0] v;
        v = b[PTR-1:0];
        return v ^ (v >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRegs();
        checkOutput("waddr", 32'(waddr), 32'(wcnt % DEPTH));
        checkOutput("wptr_gray", 32'(wptr_gray), 32'(to_gray(wcnt)));
        checkOutput("full", 32'(full), 32'(m_full));
        checkOutput("almost_full", 32'(almost_full), 32'(m_af));
        checkOutput("wr_count", 32'(wr_count), 32'(m_fill));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called at a negedge: drive inputs, check the combinational accept, advance
    // the model across the coming posedge, then check registered outputs.
    task automatic applyStimulus(input bit we, input int rd_next);
        int rsync;
        bit acc;
        wr_en = we;
        rd = rd_next % MODV;
        rptr_gray_async = to_gray(rd);
        #1;
        checkOutput("wr_accept", 32'(wr_accept), 32'(we && !m_full));
        rsync  = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
        acc    = we && !m_full;
        m_ovf  = we && m_full;
        wcnt   = (wcnt + int'(acc)) % MODV;
        m_fill = (wcnt - rsync + MODV) % MODV;
        m_full = (m_fill == DEPTH);
        m_af   = (m_fill >= AF);
        hist.push_back(rd);
        @(posedge clk);
        @(negedge clk);
        checkRegs();
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible at once.
    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        wr_en = 1'b1;
        #1;
        wcnt = 0; rd = 0; m_fill = 0;
        m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        hist.delete();
        checkRegs();
        checkOutput("rst_wr_accept", 32'(wr_accept), 32'd1);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            checkRegs();
        end
        rptr_gray_async = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        doReset(5);

        // Fill from empty with the read pointer parked at zero.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 0);
            if (i == AF - 1) checkOutput("af_before", 32'(almost_full), 32'd0);
            if (i == AF) checkOutput("af_at_level", 32'(almost_full), 32'd1);
            if (i == DEPTH - 1) checkOutput("not_full_15", 32'(full), 32'd0);
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_gray", 32'(wptr_gray), 32'b11000);
        checkOutput("fill_count", 32'(wr_count), 32'd16);

        // Writes while full are rejected and reported one cycle later.
        repeat (3) begin
            applyStimulus(1'b1, 0);
            checkOutput("ovf_pulse", 32'(overflow), 32'd1);
            checkOutput("ovf_waddr", 32'(waddr), 32'd0);
        end
        applyStimulus(1'b0, 0);
        checkOutput("ovf_clear", 32'(overflow), 32'd0);

        // One read: full must hold for two edges and drop on the third.
        applyStimulus(1'b0, 1);
        checkOutput("drain_e1", 32'(full), 32'd1);
        applyStimulus(1'b0, 1);
        checkOutput("drain_e2", 32'(full), 32'd1);
        applyStimulus(1'b0, 1);
        checkOutput("drain_e3", 32'(full), 32'd0);
        checkOutput("drain_count", 32'(wr_count), 32'd15);
        checkOutput("drain_af", 32'(almost_full), 32'd1);

        // Refill to full, then reset mid-operation.
        applyStimulus(1'b1, 1);
        checkOutput("refull", 32'(full), 32'd1);
        doReset(2);

        // Wrap with the reader trailing four entries behind.
        repeat (4) applyStimulus(1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, (wcnt + MODV - 4) % MODV);
            checkOutput("wrap_nofull", 32'(full), 32'd0);
            if (wcnt == 0) checkOutput("wrap_gray", 32'(wptr_gray), 32'b00000);
            if (wcnt == 31) checkOutput("wrap_gray31", 32'(wptr_gray), 32'b10000);
        end

        // A write lands on the edge where a read increment is first seen.
        doReset(1);
        repeat (15) applyStimulus(1'b1, 0);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        checkOutput("simul_count", 32'(wr_count), 32'd15);
        checkOutput("simul_full", 32'(full), 32'd0);

        // Random traffic with a reader that never passes the writer.
        for (int i = 0; i < 400; i++) begin
            int wprob;
            int rnext;
            bit we;
            if (i == 200) doReset(2);
            wprob = ((i / 50) % 2 == 0) ? 80 : 35;
            we = ($urandom_range(0, 99) < wprob);
            rnext = rd;
            if (rd != wcnt && $urandom_range(0, 99) < 55) rnext = (rd + 1) % MODV;
            applyStimulus(we, rnext);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
